fetch_redirect: RTL and testbench

Instruction-fetch front end that consumes the branch/jump resolution output of the execute stage: it owns the PC register, issues instruction-memory requests, and loads the F/D latch. When a taken branch or jump (including `jal`, `jr`, `bex`) is resolved in execute, it applies the redirect and squashes wrong-path instructions. Sits between instruction memory and the decode stage; its `fd_pc` output is the PC+1 value carried down the pipeline as the branch base.

---
 rtl/fetch_redirect_pkg.sv | 16 +
 rtl/cla_full_adder.sv | 37 +++
 rtl/fd_skid_buffer.sv | 31 +++
 rtl/fetch_redirect.sv | 145 ++++++++++++++
 tb/tb_fetch_redirect.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_redirect_pkg.sv
// Shared types for the fetch front end: FSM encoding, F/D bundle, NOP word.
package fetch_redirect_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] NOP_WORD = 32'd0;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DROP = 2'd1,
    HOLD = 2'd2
  } fr_state_e;

  typedef struct packed {
    logic [PC_W-1:0] ir;
    logic [PC_W-1:0] pc;
  } fd_t;
endpackage

// File: rtl/cla_full_adder.sv
// Carry-lookahead adder built from 4-bit lookahead groups.
module cla_full_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum
);
  localparam int NG = W / 4;

  logic [NG-1:0] w_gc;
  assign w_gc[0] = i_cin;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;
    assign w_g = i_a[4*k +: 4] & i_b[4*k +: 4];
    assign w_p = i_a[4*k +: 4] ^ i_b[4*k +: 4];
    assign w_c[0] = w_gc[k];
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign o_sum[4*k +: 4] = w_p ^ w_c;
    if (k + 1 < NG) begin : g_carry
      // Group generate/propagate feeds the next group directly.
      assign w_gc[k+1] = w_g[3] | (w_p[3] & w_g[2])
                       | (w_p[3] & w_p[2] & w_g[1])
                       | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                       | (&w_p & w_c[0]);
    end
  end
endmodule

// File: rtl/fd_skid_buffer.sv
// One-entry {ir, pc+1} holding register used while decode is stalled.
module fd_skid_buffer
  import fetch_redirect_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  input  logic i_clear,
  input  fd_t  i_d,
  output fd_t  o_q,
  output logic o_valid
);
  fd_t  r_q;
  logic r_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_q     <= i_d;
      r_valid <= 1'b1;
    end
  end

  assign o_q     = r_q;
  assign o_valid = r_valid;
endmodule

// File: rtl/fetch_redirect.sv
// Fetch front end: owns PC, talks to imem, loads F/D, applies
// execute-stage redirects and squashes wrong-path fetches.
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] NOP      = NOP_WORD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] fd_ir,
  output logic [31:0] fd_pc,
  output logic        fd_valid,
  output logic        flush_dx
);
  fr_state_e   r_state, w_state;
  logic [31:0] r_pc, w_pc;
  logic [31:0] r_tgt, w_tgt;
  logic [31:0] r_ir, w_ir;
  logic [31:0] r_fdpc, w_fdpc;
  logic        r_valid, w_valid;
  logic [31:0] w_pc_inc;
  logic        w_buf_load;
  logic        w_buf_clear;
  logic        w_buf_valid;
  fd_t         w_buf_q;

  cla_full_adder #(.W(32)) u_inc (
    .i_a   (r_pc),
    .i_b   (32'd0),
    .i_cin (1'b1),
    .o_sum (w_pc_inc)
  );

  fd_skid_buffer u_skid (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_d     ({imem_data, w_pc_inc}),
    .o_q     (w_buf_q),
    .o_valid (w_buf_valid)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_tgt   <= RESET_PC;
      r_ir    <= NOP;
      r_fdpc  <= 32'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_tgt   <= w_tgt;
      r_ir    <= w_ir;
      r_fdpc  <= w_fdpc;
      r_valid <= w_valid;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_pc        = r_pc;
    w_tgt       = r_tgt;
    w_ir        = r_ir;
    w_fdpc      = r_fdpc;
    w_valid     = r_valid;
    w_buf_load  = 1'b0;
    w_buf_clear = 1'b0;
    unique case (r_state)
      RUN: begin
        if (redirect_valid) begin
          w_ir    = NOP;
          w_fdpc  = 32'd0;
          w_valid = 1'b0;
          if (imem_ack) begin
            w_pc = redirect_pc;
          end else begin
            w_tgt   = redirect_pc;
            w_state = DROP;
          end
        end else if (stall) begin
          if (imem_ack) begin
            w_buf_load = 1'b1;
            w_pc       = w_pc_inc;
            w_state    = HOLD;
          end
        end else if (imem_ack) begin
          w_ir    = imem_data;
          w_fdpc  = w_pc_inc;
          w_valid = 1'b1;
          w_pc    = w_pc_inc;
        end else begin
          w_ir    = NOP;
          w_fdpc  = 32'd0;
          w_valid = 1'b0;
        end
      end
      DROP: begin
        // Wrong-path response is still owed; wait it out, then jump.
        w_ir    = NOP;
        w_fdpc  = 32'd0;
        w_valid = 1'b0;
        if (redirect_valid) w_tgt = redirect_pc;
        if (imem_ack) begin
          w_pc    = redirect_valid ? redirect_pc : r_tgt;
          w_state = RUN;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_buf_clear = 1'b1;
          w_pc        = redirect_pc;
          w_ir        = NOP;
          w_fdpc      = 32'd0;
          w_valid     = 1'b0;
          w_state     = RUN;
        end else if (!stall) begin
          w_buf_clear = 1'b1;
          w_ir        = w_buf_q.ir;
          w_fdpc      = w_buf_q.pc;
          w_valid     = w_buf_valid;
          w_state     = RUN;
        end
      end
      default: w_state = RUN;
    endcase
  end

  assign imem_req  = (r_state != HOLD);
  assign imem_addr = r_pc;
  assign fd_ir     = r_ir;
  assign fd_pc     = r_fdpc;
  assign fd_valid  = r_valid;
  assign flush_dx  = redirect_valid;
endmodule

// File: tb/tb_fetch_redirect.sv
// Scoreboard bench: directed redirect/stall/wrap/reset scenarios on fetch_redirect.
module tb_fetch_redirect;
  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] fd_ir;
  logic [31:0] fd_pc;
  logic        fd_valid;
  logic        flush_dx;

  int n_chk  = 0;
  int n_pass = 0;
  int waits  = 0;
  int cnt;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
  } exp_t;
  exp_t q[$];

  fetch_redirect dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .fd_ir          (fd_ir),
    .fd_pc          (fd_pc),
    .fd_valid       (fd_valid),
    .flush_dx       (flush_dx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory returns addr as data after `waits` idle cycles.
  always @(posedge clock or posedge reset) begin
    if (reset) cnt <= 0;
    else if (!imem_req || imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end
  assign imem_ack  = imem_req && (cnt == waits);
  assign imem_data = imem_addr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push(input logic [31:0] ir, input logic [31:0] pc);
    exp_t e;
    e.ir = ir;
    e.pc = pc;
    q.push_back(e);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Monitor: a non-stalled edge that leaves fd_valid high is a fresh load.
  initial begin
    logic st;
    exp_t e;
    forever begin
      @(posedge clock);
      st = stall;
      #1;
      if (!st && fd_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL mon_unexpected: got ir %h pc %h expected none",
                   fd_ir, fd_pc);
        end else begin
          e = q.pop_front();
          chk("mon_ir", fd_ir, e.ir);
          chk("mon_pc", fd_pc, e.pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    repeat (2) step();
    reset = 1'b0;
    #1;
    chk("rst_valid", {31'd0, fd_valid}, 32'd0);
    chk("rst_ir", fd_ir, 32'd0);
    chk("rst_fdpc", fd_pc, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'd0);
    for (int i = 0; i < 5; i++) push(i, i + 1);
    repeat (5) step();
    chk("r1_addr", imem_addr, 32'd5);
    chk("r1_ack", {31'd0, imem_ack}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("r1_flush", {31'd0, flush_dx}, 32'd1);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("r1_ir_nop", fd_ir, 32'd0);
    chk("r1_valid", {31'd0, fd_valid}, 32'd0);
    chk("r1_addr40", imem_addr, 32'h40);
    chk("r1_noflush", {31'd0, flush_dx}, 32'd0);
    push(32'h40, 32'h41);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'd8;
    step();
    redirect_valid = 1'b0;
    waits = 3;
    #1;
    chk("d_addr8", imem_addr, 32'd8);
    chk("d_noack", {31'd0, imem_ack}, 32'd0);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    step();
    chk("d_hold8", imem_addr, 32'd8);
    chk("d_req", {31'd0, imem_req}, 32'd1);
    redirect_pc = 32'h90;
    #1;
    chk("d_flush", {31'd0, flush_dx}, 32'd1);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("d_ack_addr", imem_addr, 32'd8);
    chk("d_ack", {31'd0, imem_ack}, 32'd1);
    step();
    chk("d_addr90", imem_addr, 32'h90);
    chk("d_valid", {31'd0, fd_valid}, 32'd0);
    waits = 0;
    push(32'h90, 32'h91);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'd9;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("s_addr9", imem_addr, 32'd9);
    push(32'd9, 32'd10);
    step();
    chk("s_addr10", imem_addr, 32'd10);
    chk("s_ack10", {31'd0, imem_ack}, 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s_req", {31'd0, imem_req}, 32'd0);
      chk("s_ir", fd_ir, 32'd9);
      chk("s_fdpc", fd_pc, 32'd10);
      chk("s_valid", {31'd0, fd_valid}, 32'd1);
    end
    stall = 1'b0;
    push(32'd10, 32'd11);
    step();
    chk("s_addr11", imem_addr, 32'd11);
    stall = 1'b1;
    step();
    chk("h_req", {31'd0, imem_req}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    stall = 1'b0;
    #1;
    chk("h_addr20", imem_addr, 32'h20);
    chk("h_valid", {31'd0, fd_valid}, 32'd0);
    chk("h_req1", {31'd0, imem_req}, 32'd1);
    push(32'h20, 32'h21);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("w_addr", imem_addr, 32'hFFFF_FFFF);
    push(32'hFFFF_FFFF, 32'd0);
    step();
    chk("w_addr0", imem_addr, 32'd0);
    push(32'd0, 32'd1);
    step();
    stall = 1'b1;
    waits = 3;
    #1;
    chk("a_noack", {31'd0, imem_ack}, 32'd0);
    chk("a_pre_fdpc", fd_pc, 32'd1);
    chk("a_pre_addr", imem_addr, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("a_valid", {31'd0, fd_valid}, 32'd0);
    chk("a_fdpc", fd_pc, 32'd0);
    chk("a_ir", fd_ir, 32'd0);
    chk("a_addr", imem_addr, 32'd0);
    chk("a_req", {31'd0, imem_req}, 32'd1);
    step();
    reset = 1'b0;
    stall = 1'b0;
    waits = 0;
    push(32'd0, 32'd1);
    push(32'd1, 32'd2);
    repeat (2) step();
    stall = 1'b1;
    repeat (2) step();
    chk("q_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
